fir_unfolded_ctrl: RTL and testbench

- Sequencing controller in front of and behind the 3-parallel unfolded FIR (8-bit data, 11 taps).
- Packs a serial valid/ready sample stream into 3-sample blocks on DIN0..DIN2 with a one-cycle VIN strobe.
- Unpacks DOUT0..DOUT2 back into a serial valid/ready stream.
- Owns the H0..H10 coefficient registers: a shadow bank plus an active bank, with safe commit.

---
 rtl/fir_unfolded_pkg.sv | 8 +
 rtl/blk_fifo.sv | 38 +++
 rtl/fir_unfolded_ctrl.sv | 110 +++++++++++
 tb/tb_fir_unfolded_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_unfolded_pkg.sv
// fir_unfolded_pkg: shared widths, FSM states and tag type for the unfolded FIR controller
package fir_unfolded_pkg;
  localparam int DW = 8;
  localparam int NTAPS = 11;
  localparam int P = 3;
  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;
  typedef logic [1:0] tag_t;
endpackage

// File: rtl/blk_fifo.sv
// blk_fifo: small synchronous FIFO holding whole filter blocks or their tags
module blk_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o
);
  localparam int AW = (D > 1) ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  logic [W-1:0] mem_q [D];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (cnt_q != CW'(D) || do_pop);
  assign dout_o = mem_q[rp_q];
  // storage is never reset; reads are only meaningful while not empty
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wp_q] <= din_i;
  // wrap-around pointers and occupancy count
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q == AW'(D - 1) ? '0 : wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q == AW'(D - 1) ? '0 : rp_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fir_unfolded_ctrl.sv
// fir_unfolded_ctrl: packs/unpacks serial samples for the 3-parallel FIR and owns its coefficient banks
module fir_unfolded_ctrl
  import fir_unfolded_pkg::*;
#(
  parameter int NBLK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [DW-1:0]       s_din_i,
  input  logic                s_vin_i,
  output logic                s_ready_o,
  input  logic                flush_i,
  input  logic                coef_we_i,
  input  logic [3:0]          coef_addr_i,
  input  logic [DW-1:0]       coef_data_i,
  input  logic                coef_commit_i,
  output logic [DW-1:0]       f_din0_o,
  output logic [DW-1:0]       f_din1_o,
  output logic [DW-1:0]       f_din2_o,
  output logic                f_vin_o,
  output logic [NTAPS*DW-1:0] h_bus_o,
  input  logic [DW-1:0]       f_dout0_i,
  input  logic [DW-1:0]       f_dout1_i,
  input  logic [DW-1:0]       f_dout2_i,
  input  logic                f_vout_i,
  output logic [DW-1:0]       m_dout_o,
  output logic                m_vout_o,
  input  logic                m_ready_i,
  output logic                busy_o,
  output logic                err_o
);
  localparam int CW = $clog2(NBLK + 1);
  state_t state_q;
  logic [NTAPS*DW-1:0] sh_q, act_q;
  logic [P-1:0][DW-1:0] sl_q, sl_d, blk_q, blk_d;
  logic [1:0] cnt_q, idx_q;
  tag_t n, tg_head;
  logic [CW-1:0] cred_q, infl_q;
  logic [P*DW-1:0] bf_dout;
  logic flush_q, vin_q, err_q;
  logic acc, fl, avail, iss, cret, fv_ok, m_hs, last, bf_empty, tf_empty;
  assign s_ready_o = !rst_i && state_q == RUN && cnt_q != 2'd3;
  assign acc = s_vin_i && s_ready_o;
  assign n = cnt_q + {1'b0, acc};
  assign fl = flush_q || flush_i;
  assign avail = cred_q != '0 || cret;
  assign iss = state_q == RUN && avail && (n == 2'd3 || (fl && n != 2'd0));
  assign fv_ok = f_vout_i && infl_q != '0;
  assign m_vout_o = !bf_empty;
  assign m_dout_o = m_vout_o ? bf_dout[idx_q*DW +: DW] : '0;
  assign m_hs = m_vout_o && m_ready_i;
  assign last = idx_q == tg_head - 2'd1;
  assign cret = m_hs && last;
  assign {f_din2_o, f_din1_o, f_din0_o} = blk_q;
  assign f_vin_o = vin_q;
  assign h_bus_o = act_q;
  assign err_o = err_q;
  assign busy_o = state_q != RUN || cnt_q != 2'd0 || infl_q != '0 || !bf_empty || !tf_empty;
  // accepted sample lands in the next free slot; slots beyond the valid count are zero-padded
  always_comb begin
    sl_d = sl_q;
    if (acc) sl_d[cnt_q] = s_din_i;
    blk_d = sl_d;
    if (n < 2'd3) blk_d[2] = '0;
    if (n < 2'd2) blk_d[1] = '0;
  end
  // packer, credits, in-flight count, unpacker index and sticky error
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      sl_q <= '0;
      blk_q <= '0;
      cnt_q <= '0;
      vin_q <= 1'b0;
      flush_q <= 1'b0;
      cred_q <= CW'(NBLK);
      infl_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      sl_q <= sl_d;
      cnt_q <= iss ? 2'd0 : n;
      flush_q <= fl && !iss && (n == 2'd1 || n == 2'd2);
      vin_q <= iss;
      if (iss) blk_q <= blk_d;
      cred_q <= cred_q - CW'(iss) + CW'(cret);
      infl_q <= infl_q + CW'(iss) - CW'(fv_ok);
      if (m_hs) idx_q <= last ? 2'd0 : idx_q + 2'd1;
      err_q <= err_q || (f_vout_i && infl_q == '0);
    end
  // commit FSM: drain in-flight blocks, then copy shadow into active bank for one LOAD cycle
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= RUN;
      sh_q <= '0;
      act_q <= '0;
    end else begin
      if (coef_we_i && int'(coef_addr_i) < NTAPS) sh_q[int'(coef_addr_i)*DW +: DW] <= coef_data_i;
      if (state_q == LOAD) act_q <= sh_q;
      state_q <= state_q == RUN ? (coef_commit_i ? DRAIN : RUN) :
                 state_q == DRAIN ? (infl_q == '0 ? LOAD : DRAIN) : RUN;
    end
  blk_fifo #(.W(P*DW), .D(NBLK)) u_bf (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(fv_ok), .din_i({f_dout2_i, f_dout1_i, f_dout0_i}),
    .pop_i(cret), .dout_o(bf_dout), .empty_o(bf_empty)
  );
  blk_fifo #(.W(2), .D(NBLK)) u_tf (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(iss), .din_i(n),
    .pop_i(cret), .dout_o(tg_head), .empty_o(tf_empty)
  );
endmodule

// File: tb/tb_fir_unfolded_ctrl.sv
// tb_fir_unfolded_ctrl: directed self-checking bench for the unfolded FIR controller
module tb_fir_unfolded_ctrl;
  import fir_unfolded_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] s_din = '0, coef_data = '0;
  logic [3:0] coef_addr = '0;
  logic s_vin = 1'b0, flush = 1'b0, coef_we = 1'b0, commit = 1'b0, m_ready = 1'b1;
  logic [7:0] f_din0, f_din1, f_din2, m_dout;
  logic f_vin, s_ready, m_vout, busy, err, f_vout;
  logic [NTAPS*DW-1:0] h_bus;
  logic [23:0] f_dout;
  logic auto_f = 1'b1, man_v = 1'b0;
  logic [23:0] man_d = '0;
  logic v1 = 1'b0, v2 = 1'b0;
  logic [23:0] d1 = '0, d2 = '0;
  logic [23:0] fq[$];
  logic [7:0] mq[$];
  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  fir_unfolded_ctrl #(.NBLK(4)) dut (
    .clk_i(clk), .rst_i(rst), .s_din_i(s_din), .s_vin_i(s_vin), .s_ready_o(s_ready),
    .flush_i(flush), .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
    .coef_commit_i(commit), .f_din0_o(f_din0), .f_din1_o(f_din1), .f_din2_o(f_din2),
    .f_vin_o(f_vin), .h_bus_o(h_bus), .f_dout0_i(f_dout[7:0]), .f_dout1_i(f_dout[15:8]),
    .f_dout2_i(f_dout[23:16]), .f_vout_i(f_vout), .m_dout_o(m_dout), .m_vout_o(m_vout),
    .m_ready_i(m_ready), .busy_o(busy), .err_o(err)
  );

  // identity filter with a fixed two-cycle latency, or manual drive
  always @(posedge clk) begin
    v1 <= !rst && auto_f && f_vin;
    d1 <= {f_din2, f_din1, f_din0};
    v2 <= !rst && v1;
    d2 <= d1;
  end
  assign f_vout = auto_f ? v2 : man_v;
  assign f_dout = auto_f ? d2 : man_d;

  // record issued blocks and output handshakes that take effect at the next edge
  always begin
    @(negedge clk);
    #1;
    if (f_vin) fq.push_back({f_din2, f_din1, f_din0});
    if (m_vout && m_ready) mq.push_back(m_dout);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = d;
    step(1);
    coef_we = 1'b0;
  endtask

  task automatic deliver(input logic [23:0] d);
    man_v = 1'b1;
    man_d = d;
    step(1);
    man_v = 1'b0;
  endtask

  initial begin
    logic [NTAPS*DW-1:0] hx;
    int nxt;
    logic acc;
    step(3);
    chk("rst_sready", s_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(1);
    chk("rel_sready", s_ready, 1);
    chk("rel_fvin", f_vin, 0);
    chk("rel_mvout", m_vout, 0);
    chk("rel_mdout", m_dout, 0);
    chk("rel_hbus", h_bus, 0);
    chk("rel_err", err, 0);
    chk("rel_busy", busy, 0);

    hx = '0;
    for (int i = 0; i < NTAPS; i++) begin
      wr(4'(i), 8'(i + 1));
      hx[i*8 +: 8] = 8'(i + 1);
    end
    wr(4'd11, 8'hFF);
    wr(4'd15, 8'hEE);
    chk("h_shadow_only", h_bus, 0);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    chk("drain_sready", s_ready, 0);
    chk("drain_busy", busy, 1);
    step(1);
    chk("load_hbus_old", h_bus, 0);
    step(1);
    chk("h_committed", h_bus, hx);
    chk("run_sready", s_ready, 1);
    chk("run_busy", busy, 0);

    wr(4'd0, 8'd1);
    for (int i = 1; i < NTAPS; i++) wr(4'(i), 8'd0);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(1);
    wr(4'd1, 8'h55);
    chk("h_identity", h_bus, 88'h1);

    fq.delete();
    mq.delete();
    s_vin = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      s_din = 8'(k);
      step(1);
      if (k == 1) chk("fvin_early", f_vin, 0);
      if (k == 3) begin
        chk("fvin_blk1", f_vin, 1);
        chk("fdin_blk1", {f_din2, f_din1, f_din0}, 24'h030201);
      end
    end
    s_vin = 1'b0;
    step(10);
    chk("blk_count", fq.size(), 3);
    chk("blk0", fq[0], 24'h030201);
    chk("blk1", fq[1], 24'h060504);
    chk("blk2", fq[2], 24'h090807);
    chk("out_count", mq.size(), 9);
    for (int i = 0; i < 9; i++) chk("out_seq", mq[i], 8'(i + 1));
    chk("idle_busy", busy, 0);

    mq.delete();
    s_vin = 1'b1;
    s_din = 8'd10;
    step(1);
    s_din = 8'd11;
    step(1);
    s_vin = 1'b0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_fvin", f_vin, 1);
    chk("flush_blk", {f_din2, f_din1, f_din0}, 24'h000B0A);
    step(8);
    chk("flush_outs", mq.size(), 2);
    chk("flush_o0", mq[0], 10);
    chk("flush_o1", mq[1], 11);
    chk("flush_busy", busy, 0);

    fq.delete();
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    step(3);
    chk("flush_empty_noop", fq.size(), 0);

    mq.delete();
    s_vin = 1'b1;
    s_din = 8'd12;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    s_din = 8'd13;
    step(1);
    s_din = 8'd14;
    step(1);
    s_din = 8'd15;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    s_vin = 1'b0;
    step(10);
    chk("fs_blk_count", fq.size(), 2);
    chk("fs_blk_tag1", fq[0], 24'h00000C);
    chk("fs_blk_full", fq[1], 24'h0F0E0D);
    chk("fs_out_count", mq.size(), 4);
    for (int i = 0; i < 4; i++) chk("fs_out_seq", mq[i], 8'(12 + i));

    mq.delete();
    m_ready = 1'b0;
    nxt = 20;
    s_vin = 1'b1;
    repeat (25) begin
      s_din = 8'(nxt);
      acc = s_ready;
      step(1);
      if (acc) nxt++;
    end
    chk("bp_accepted", nxt, 35);
    chk("bp_sready", s_ready, 0);
    chk("bp_mvout", m_vout, 1);
    chk("bp_mdout_hold", m_dout, 20);
    chk("bp_busy", busy, 1);
    s_vin = 1'b0;
    m_ready = 1'b1;
    step(1);
    chk("bp_fvin_e1", f_vin, 0);
    step(1);
    chk("bp_fvin_e2", f_vin, 0);
    step(1);
    chk("bp_fvin_resume", f_vin, 1);
    chk("bp_held_blk", {f_din2, f_din1, f_din0}, 24'h222120);
    step(25);
    chk("bp_out_count", mq.size(), 15);
    for (int i = 0; i < 15; i++) chk("bp_out_seq", mq[i], 8'(20 + i));
    chk("bp_busy_end", busy, 0);

    auto_f = 1'b0;
    mq.delete();
    s_vin = 1'b1;
    for (int k = 40; k <= 45; k++) begin
      s_din = 8'(k);
      step(1);
    end
    s_din = 8'd46;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    s_vin = 1'b0;
    chk("cm_sready", s_ready, 0);
    chk("cm_busy", busy, 1);
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(2);
    chk("cm_drain_hold", s_ready, 0);
    chk("cm_drain_hbus", h_bus, 88'h1);
    deliver(24'h2A2928);
    chk("unpack_lat_v", m_vout, 1);
    chk("unpack_lat_d", m_dout, 8'h28);
    deliver(24'h2D2C2B);
    chk("cm_drain_last", s_ready, 0);
    step(1);
    chk("cm_load_sready", s_ready, 0);
    chk("cm_load_hbus", h_bus, 88'h1);
    step(1);
    chk("cm_new_hbus", h_bus, 88'h5501);
    chk("cm_run_sready", s_ready, 1);
    s_vin = 1'b1;
    s_din = 8'd47;
    step(1);
    s_din = 8'd48;
    step(1);
    s_vin = 1'b0;
    chk("cm_partial_fvin", f_vin, 1);
    chk("cm_partial_blk", {f_din2, f_din1, f_din0}, 24'h302F2E);
    step(1);
    deliver(24'h302F2E);
    step(6);
    chk("cm_out_count", mq.size(), 9);
    for (int i = 0; i < 9; i++) chk("cm_out_seq", mq[i], 8'(40 + i));
    chk("cm_busy_end", busy, 0);

    chk("err_before", err, 0);
    deliver(24'h636363);
    chk("err_set", err, 1);
    chk("err_ignored", m_vout, 0);
    step(3);
    chk("err_sticky", err, 1);

    auto_f = 1'b1;
    s_vin = 1'b1;
    s_din = 8'd50;
    step(1);
    s_din = 8'd51;
    step(1);
    s_din = 8'd52;
    step(1);
    s_vin = 1'b0;
    chk("mid_fvin", f_vin, 1);
    rst = 1'b1;
    step(1);
    chk("mr_fvin", f_vin, 0);
    chk("mr_fdin", {f_din2, f_din1, f_din0}, 0);
    chk("mr_sready", s_ready, 0);
    chk("mr_err", err, 0);
    chk("mr_hbus", h_bus, 0);
    chk("mr_busy", busy, 0);
    chk("mr_mvout", m_vout, 0);
    chk("mr_mdout", m_dout, 0);
    rst = 1'b0;
    step(3);
    chk("mr_rel_sready", s_ready, 1);
    chk("mr_rel_err", err, 0);
    chk("mr_rel_mvout", m_vout, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
